// File: rtl/pe_array_stu_arbiter.sv
// Round-robin, packet-locked arbiter that shares the single STU upstream port among all PEs.
// One PE owns the output register from its first accepted beat until it sends EOM/SOM_EOM.
module pe_array_stu_arbiter #(
  parameter int NUM_PE = 4,
  parameter int ID_W   = $clog2(NUM_PE),
  parameter int CNTL_W = 2,
  parameter int TYPE_W = 2,
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic [NUM_PE-1:0]          pe__stu__valid,
  input  logic [NUM_PE*CNTL_W-1:0]   pe__stu__cntl,
  input  logic [NUM_PE*TYPE_W-1:0]   pe__stu__type,
  input  logic [NUM_PE*DATA_W-1:0]   pe__stu__data,
  input  logic [NUM_PE*OOB_W-1:0]    pe__stu__oob_data,
  output logic [NUM_PE-1:0]          stu__pe__ready,
  output logic                       arb__stu__valid,
  output logic [CNTL_W-1:0]          arb__stu__cntl,
  output logic [TYPE_W-1:0]          arb__stu__type,
  output logic [DATA_W-1:0]          arb__stu__data,
  output logic [OOB_W-1:0]           arb__stu__oob_data,
  output logic [ID_W-1:0]            arb__stu__peId,
  input  logic                       stu__arb__ready
);

  localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(2'b10);
  localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(2'b11);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  logic              sel_valid;
  logic [CNTL_W-1:0] sel_cntl;
  logic [TYPE_W-1:0] sel_type;
  logic [DATA_W-1:0] sel_data;
  logic [OOB_W-1:0]  sel_oob;

  logic              slot_free;
  logic              accept;
  logic              last_beat;
  logic [ID_W-1:0]   grant_next_id;

  // First requesting PE at or after the round-robin pointer, wrapping around.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = rr_ptr_q;
    idx        = 0;
    for (int k = 0; k < NUM_PE; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_PE;
      if (!pick_found && pe__stu__valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_cntl  = '0;
    sel_type  = '0;
    sel_data  = '0;
    sel_oob   = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = pe__stu__valid[i];
        sel_cntl  = pe__stu__cntl[i*CNTL_W +: CNTL_W];
        sel_type  = pe__stu__type[i*TYPE_W +: TYPE_W];
        sel_data  = pe__stu__data[i*DATA_W +: DATA_W];
        sel_oob   = pe__stu__oob_data[i*OOB_W +: OOB_W];
      end
    end
  end

  // The output register can take a beat when empty or when its current beat is leaving.
  assign slot_free     = !arb__stu__valid || stu__arb__ready;
  assign accept        = (state_q == ST_LOCKED) && sel_valid && slot_free;
  assign last_beat     = (sel_cntl == CNTL_EOM) || (sel_cntl == CNTL_SOM_EOM);
  assign grant_next_id = (grant_q == ID_W'(NUM_PE - 1)) ? '0 : grant_q + ID_W'(1);

  always_comb begin
    stu__pe__ready = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      stu__pe__ready[i] = (state_q == ST_LOCKED) && (grant_q == ID_W'(i)) && slot_free;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept && last_beat) begin
          rr_ptr_d = grant_next_id;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Held beat stays untouched under backpressure; a same-cycle take and accept just overwrites it.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      arb__stu__valid    <= 1'b0;
      arb__stu__cntl     <= '0;
      arb__stu__type     <= '0;
      arb__stu__data     <= '0;
      arb__stu__oob_data <= '0;
      arb__stu__peId     <= '0;
    end else if (accept) begin
      arb__stu__valid    <= 1'b1;
      arb__stu__cntl     <= sel_cntl;
      arb__stu__type     <= sel_type;
      arb__stu__data     <= sel_data;
      arb__stu__oob_data <= sel_oob;
      arb__stu__peId     <= grant_q;
    end else if (stu__arb__ready) begin
      arb__stu__valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_array_stu_arbiter.sv
// Directed bench for pe_array_stu_arbiter: PE source models feed packets, a scoreboard
// monitor checks every beat taken by the STU against the expected grant order.
module tb_pe_array_stu_arbiter;

  localparam int NUM_PE = 4;

  typedef struct {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
    int          gap;
  } stim_t;

  typedef struct {
    logic [1:0]  pe;
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
  } exp_t;

  logic                 clk;
  logic                 reset_poweron;
  logic [NUM_PE-1:0]    pe_valid;
  logic [NUM_PE*2-1:0]  pe_cntl;
  logic [NUM_PE*2-1:0]  pe_type;
  logic [NUM_PE*64-1:0] pe_data;
  logic [NUM_PE*32-1:0] pe_oob;
  logic [NUM_PE-1:0]    pe_ready;
  logic                 arb_valid;
  logic [1:0]           arb_cntl;
  logic [1:0]           arb_type;
  logic [63:0]          arb_data;
  logic [31:0]          arb_oob;
  logic [1:0]           arb_pe_id;
  logic                 stu_ready;

  stim_t       pe_q [NUM_PE][$];
  exp_t        exp_q[$];
  int          gap_cnt [NUM_PE];
  logic [NUM_PE-1:0] fire;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int first_cyc = -1;
  int last_cyc  = -1;

  pe_array_stu_arbiter #(
    .NUM_PE(4), .ID_W(2), .CNTL_W(2), .TYPE_W(2), .DATA_W(64), .OOB_W(32)
  ) dut (
    .clk                (clk),
    .reset_poweron      (reset_poweron),
    .pe__stu__valid     (pe_valid),
    .pe__stu__cntl      (pe_cntl),
    .pe__stu__type      (pe_type),
    .pe__stu__data      (pe_data),
    .pe__stu__oob_data  (pe_oob),
    .stu__pe__ready     (pe_ready),
    .arb__stu__valid    (arb_valid),
    .arb__stu__cntl     (arb_cntl),
    .arb__stu__type     (arb_type),
    .arb__stu__data     (arb_data),
    .arb__stu__oob_data (arb_oob),
    .arb__stu__peId     (arb_pe_id),
    .stu__arb__ready    (stu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] cntl_of(input int k, input int n);
    if (n == 1)          return 2'b11;
    else if (k == 0)     return 2'b01;
    else if (k == n - 1) return 2'b10;
    else                 return 2'b00;
  endfunction

  // Queue one packet on a PE; when expect_it is set the beats are also expected at the STU in call order.
  task automatic applyStimulus(input int pe, input int nbeats, input int mid_gap, input int tag, input bit expect_it);
    stim_t s;
    exp_t  e;
    for (int k = 0; k < nbeats; k++) begin
      s.cntl = cntl_of(k, nbeats);
      s.typ  = 2'(k);
      s.data = {16'hC0DE, 16'(tag), 16'(pe), 16'(k)};
      s.oob  = {8'(tag), 8'hA5, 8'(pe), 8'(k)};
      s.gap  = (k == 1) ? mid_gap : 0;
      if (k == 0 && pe_q[pe].size() == 0) gap_cnt[pe] = 0;
      pe_q[pe].push_back(s);
      if (expect_it) begin
        e.pe   = 2'(pe);
        e.cntl = s.cntl;
        e.typ  = s.typ;
        e.data = s.data;
        e.oob  = s.oob;
        exp_q.push_back(e);
      end
    end
  endtask

  // PE source models: hold a beat until the handshake seen at the previous negedge, then advance.
  initial begin
    pe_valid = '0;
    pe_cntl  = '0;
    pe_type  = '0;
    pe_data  = '0;
    pe_oob   = '0;
    fire     = '0;
    for (int i = 0; i < NUM_PE; i++) gap_cnt[i] = 0;
    forever begin
      @(negedge clk);
      fire = pe_valid & pe_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_PE; i++) begin
        if (fire[i]) begin
          pe_valid[i] = 1'b0;
          if (pe_q[i].size() > 0) void'(pe_q[i].pop_front());
          if (pe_q[i].size() > 0) gap_cnt[i] = pe_q[i][0].gap;
        end
        if (!pe_valid[i] && pe_q[i].size() > 0) begin
          if (gap_cnt[i] > 0) begin
            gap_cnt[i]--;
          end else begin
            pe_valid[i]          = 1'b1;
            pe_cntl[i*2 +: 2]    = pe_q[i][0].cntl;
            pe_type[i*2 +: 2]    = pe_q[i][0].typ;
            pe_data[i*64 +: 64]  = pe_q[i][0].data;
            pe_oob[i*32 +: 32]   = pe_q[i][0].oob;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every beat the STU takes must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_poweron && arb_valid && stu_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected beat: got peId %0d data %0h, expected no beat", arb_pe_id, arb_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat peId", 64'(arb_pe_id), 64'(e.pe));
          checkOutput("beat cntl", 64'(arb_cntl), 64'(e.cntl));
          checkOutput("beat type", 64'(arb_type), 64'(e.typ));
          checkOutput("beat data", arb_data, e.data);
          checkOutput("beat oob", 64'(arb_oob), 64'(e.oob));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (|pe_ready) checkOutput("ready onehot0", 64'($onehot0(pe_ready)), 64'd1);
    end
  end

  task automatic waitDrain(input int max_cycles);
    int k = 0;
    while ((exp_q.size() != 0 || pe_q[0].size() != 0 || pe_q[1].size() != 0 ||
            pe_q[2].size() != 0 || pe_q[3].size() != 0) && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain pending beats", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic waitOutputFrom(input int pe, input int max_cycles);
    int k = 0;
    @(negedge clk);
    while (!(arb_valid && arb_pe_id == 2'(pe)) && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    checkOutput("output from expected PE seen", 64'(arb_valid && arb_pe_id == 2'(pe)), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    reset_poweron = 1'b0;
    stu_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid", 64'(arb_valid), 64'd0);
    checkOutput("reset peId", 64'(arb_pe_id), 64'd0);
    checkOutput("reset data", arb_data, 64'd0);
    checkOutput("reset ready", 64'(pe_ready), 64'd0);
    @(negedge clk);
    reset_poweron = 1'b1;

    $display("[TB] single SOM_EOM from PE2");
    @(posedge clk); #2;
    applyStimulus(2, 1, 0, 1, 1'b1);
    k = 0;
    while (!pe_valid[2] && k < 10) begin @(negedge clk); k++; end
    checkOutput("idle no ready", 64'(pe_ready), 64'd0);
    @(negedge clk);
    checkOutput("bubble cycle valid", 64'(arb_valid), 64'd0);
    checkOutput("granted ready", 64'(pe_ready), 64'b0100);
    @(negedge clk);
    checkOutput("latency valid", 64'(arb_valid), 64'd1);
    checkOutput("latency peId", 64'(arb_pe_id), 64'd2);
    waitDrain(20);

    $display("[TB] pointer after PE2: PE3 wins over PE0");
    @(posedge clk); #2;
    applyStimulus(3, 1, 0, 2, 1'b1);
    applyStimulus(0, 1, 0, 3, 1'b1);
    waitDrain(30);

    $display("[TB] reset mid-packet");
    @(posedge clk); #2;
    stu_ready = 1'b0;
    applyStimulus(1, 3, 0, 4, 1'b0);
    waitOutputFrom(1, 20);
    #3;
    reset_poweron = 1'b0;
    #1;
    checkOutput("async reset valid", 64'(arb_valid), 64'd0);
    checkOutput("async reset data", arb_data, 64'd0);
    checkOutput("async reset oob", 64'(arb_oob), 64'd0);
    checkOutput("async reset cntl", 64'(arb_cntl), 64'd0);
    checkOutput("async reset peId", 64'(arb_pe_id), 64'd0);
    checkOutput("async reset ready", 64'(pe_ready), 64'd0);
    pe_q[1].delete();
    pe_valid = '0;
    repeat (2) @(negedge clk);
    reset_poweron = 1'b1;
    stu_ready     = 1'b1;

    $display("[TB] all PEs with 3-beat packets");
    @(posedge clk); #2;
    first_cyc = -1;
    applyStimulus(0, 3, 0, 5, 1'b1);
    applyStimulus(1, 3, 0, 6, 1'b1);
    applyStimulus(2, 3, 0, 7, 1'b1);
    applyStimulus(3, 3, 0, 8, 1'b1);
    applyStimulus(0, 3, 0, 9, 1'b1);
    waitDrain(100);
    checkOutput("packet spacing", 64'(last_cyc - first_cyc), 64'd18);

    $display("[TB] STU backpressure mid-packet on PE1");
    @(posedge clk); #2;
    applyStimulus(1, 3, 0, 10, 1'b1);
    waitOutputFrom(1, 20);
    @(posedge clk); #2;
    stu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall valid", 64'(arb_valid), 64'd1);
      checkOutput("stall data", arb_data, 64'hC0DE_000A_0001_0001);
      checkOutput("stall cntl", 64'(arb_cntl), 64'd0);
      checkOutput("stall ready1", 64'(pe_ready[1]), 64'd0);
    end
    @(posedge clk); #2;
    stu_ready = 1'b1;
    waitDrain(40);

    $display("[TB] PE3 valid gap keeps lock against PE0");
    @(posedge clk); #2;
    applyStimulus(3, 3, 4, 11, 1'b1);
    applyStimulus(0, 1, 0, 12, 1'b1);
    waitOutputFrom(3, 20);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lock ready0", 64'(pe_ready[0]), 64'd0);
      checkOutput("lock ready3", 64'(pe_ready[3]), 64'd1);
      @(negedge clk);
    end
    waitDrain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
